// File: rtl/data_mem_responder.sv
// Data-memory responder for the memory stage: one outstanding load/store,
// fixed response latency, byte-lane stores, RV32I sign/zero-extended loads
// and fault reporting for misaligned, out-of-range or illegal accesses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, stateNext;
  logic [3:0] cnt, cntNext;

  // Latched request
  logic        weQ;
  logic [31:0] addrQ;
  logic [31:0] wdataQ;
  logic [2:0]  f3Q;

  // Registered response, held for the whole RESP state
  logic [31:0] rdataQ;
  logic        errQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, commit;
  logic [AW-1:0] idx;
  logic [31:0]   word, shifted, loadData;
  logic [15:0]   halfSel;
  logic [7:0]    byteSel;
  logic          outOfRange, misaligned, badF3, err;
  logic [NUM_LANES-1:0]        byteMask;
  logic [NUM_LANES-1:0][7:0]   curLanes, newLanes, mergeLanes;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdataQ;
  assign rsp_err   = errQ;

  assign accept = req_valid && req_ready;
  // The storage access happens on the single edge that enters RESP.
  assign commit = (state == WAIT) && (stateNext == RESP);

  assign idx  = addrQ[AW+1:2];
  assign word = mem[idx];

  // Next-state logic: WAIT covers the LATENCY cycles after acceptance.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: if (accept) begin
        stateNext = WAIT;
        cntNext   = 4'(LATENCY);
      end
      WAIT: if (cnt <= 4'd1) begin
        stateNext = RESP;
        cntNext   = 4'd0;
      end else begin
        cntNext = cnt - 4'd1;
      end
      RESP: if (rsp_ready) stateNext = IDLE;
      default: begin
        stateNext = IDLE;
        cntNext   = 4'd0;
      end
    endcase
  end

  // Fault decode: funct3[1:0] gives size, funct3[2] is the unsigned flag.
  always_comb begin
    outOfRange = ({2'b00, addrQ[31:2]} >= 32'(DEPTH_WORDS));
    misaligned = 1'b0;
    if (f3Q[1:0] == 2'b01) misaligned = addrQ[0];
    if (f3Q[1:0] == 2'b10) misaligned = (addrQ[1:0] != 2'b00);
    if (weQ) badF3 = (f3Q != 3'b000) && (f3Q != 3'b001) && (f3Q != 3'b010);
    else     badF3 = (f3Q == 3'b011) || (f3Q == 3'b110) || (f3Q == 3'b111);
    err = outOfRange || misaligned || badF3;
  end

  // Load extraction and extension.
  always_comb begin
    shifted  = word >> {addrQ[1:0], 3'b000};
    byteSel  = shifted[7:0];
    halfSel  = addrQ[1] ? word[31:16] : word[15:0];
    loadData = 32'd0;
    case (f3Q)
      3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
      3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
      3'b010:  loadData = word;
      3'b100:  loadData = {24'd0, byteSel};
      3'b101:  loadData = {16'd0, halfSel};
      default: loadData = 32'd0;
    endcase
  end

  // Store lane mask and replicated store data.
  always_comb begin
    byteMask = 4'b0000;
    newLanes = wdataQ;
    case (f3Q[1:0])
      2'b00: begin
        byteMask = 4'b0001 << addrQ[1:0];
        newLanes = {4{wdataQ[7:0]}};
      end
      2'b01: begin
        byteMask = addrQ[1] ? 4'b1100 : 4'b0011;
        newLanes = {2{wdataQ[15:0]}};
      end
      2'b10: byteMask = 4'b1111;
      default: byteMask = 4'b0000;
    endcase
  end

  assign curLanes = word;

  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    assign mergeLanes[g] = byteMask[g] ? newLanes[g] : curLanes[g];
  end

  // Control state, request latch and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      weQ    <= 1'b0;
      addrQ  <= 32'd0;
      wdataQ <= 32'd0;
      f3Q    <= 3'd0;
      rdataQ <= 32'd0;
      errQ   <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        weQ    <= req_we;
        addrQ  <= req_addr;
        wdataQ <= req_wdata;
        f3Q    <= req_funct3;
      end
      if (commit) begin
        rdataQ <= (err || weQ) ? 32'd0 : loadData;
        errQ   <= err;
      end else if ((state == RESP) && rsp_ready) begin
        rdataQ <= 32'd0;
        errQ   <= 1'b0;
      end
    end
  end

  // Storage write; not reset, and a reset aborts the FSM before commit.
  always_ff @(posedge clk) begin
    if (commit && weQ && !err) mem[idx] <= mergeLanes;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random accesses
// checked against a byte-addressed reference memory.
module tb_data_mem_responder;

  logic        clk, rst;
  logic        rv0, rv1, rr0, rr1, reqWe;
  logic [31:0] reqAddr, reqWdata;
  logic [2:0]  reqF3;
  logic        vl0, vl1, rsr0, rsr1, er0, er1;
  logic [31:0] rd0, rd1;

  int asserts = 0;
  int fails   = 0;
  int cycle   = 0;
  int lastAccept = 0;

  logic [7:0] mb [2][1024];

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_we(reqWe),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_funct3(reqF3),
    .rsp_valid(vl0), .rsp_ready(rsr0), .rsp_rdata(rd0), .rsp_err(er0));

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rr1), .req_we(reqWe),
    .req_addr(reqAddr), .req_wdata(reqWdata), .req_funct3(reqF3),
    .rsp_valid(vl1), .rsp_ready(rsr1), .rsp_rdata(rd1), .rsp_err(er1));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic readyOf(input int sel);
    return sel != 0 ? rr1 : rr0;
  endfunction
  function automatic logic validOf(input int sel);
    return sel != 0 ? vl1 : vl0;
  endfunction
  function automatic logic errOf(input int sel);
    return sel != 0 ? er1 : er0;
  endfunction
  function automatic logic [31:0] rdOf(input int sel);
    return sel != 0 ? rd1 : rd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: byte memory, size from funct3[1:0], sign unless funct3[2].
  function automatic void model(input int sel, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [2:0] f3,
                                output logic err, output logic [31:0] rdata);
    int sz;
    logic legal;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    err   = !legal || (addr % sz != 0) || (addr >= 32'd1024);
    rdata = 32'd0;
    if (!err) begin
      for (int b = 0; b < sz; b++) begin
        if (we) mb[sel][addr + b] = 8'(wdata >> (8 * b));
        else    rdata = rdata | (32'(mb[sel][addr + b]) << (8 * b));
      end
      if (!we && !f3[2] && sz < 4 && rdata[8 * sz - 1])
        rdata = rdata | (32'hFFFF_FFFF << (8 * sz));
    end
  endfunction

  task automatic setValid(input int sel, input logic v);
    if (sel != 0) rv1 = v; else rv0 = v;
  endtask
  task automatic setRspReady(input int sel, input logic v);
    if (sel != 0) rsr1 = v; else rsr0 = v;
  endtask

  // One full access: accept, check latency, optional hold with spurious
  // requests, consume.
  task automatic access(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input int hold, input bit spur,
                        output logic [31:0] gotRd, output logic gotErr);
    int lat, waitCnt;
    logic expErr;
    logic [31:0] expRd;
    lat = (sel != 0) ? 1 : 2;
    model(sel, we, addr, wdata, f3, expErr, expRd);
    @(negedge clk);
    waitCnt = 0;
    while (readyOf(sel) !== 1'b1 && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    chk("req_ready_idle", readyOf(sel), 1'b1);
    reqWe = we; reqAddr = addr; reqWdata = wdata; reqF3 = f3;
    setValid(sel, 1'b1);
    @(posedge clk);
    #1;
    lastAccept = cycle;
    if (spur) begin
      reqWe = 1'b1; reqAddr = 32'h30; reqWdata = 32'hBAD0BAD0; reqF3 = 3'd2;
    end else begin
      setValid(sel, 1'b0);
    end
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("rsp_valid_wait", validOf(sel), 1'b0);
      chk("req_ready_wait", readyOf(sel), 1'b0);
    end
    @(negedge clk);
    chk("rsp_valid_lat", validOf(sel), 1'b1);
    chk("rsp_rdata", rdOf(sel), expRd);
    chk("rsp_err", errOf(sel), expErr);
    gotRd = rdOf(sel);
    gotErr = errOf(sel);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", validOf(sel), 1'b1);
      chk("hold_rdata", rdOf(sel), expRd);
      chk("hold_err", errOf(sel), expErr);
      chk("req_ready_resp", readyOf(sel), 1'b0);
    end
    setValid(sel, 1'b0);
    setRspReady(sel, 1'b1);
    @(posedge clk);
    #1;
    setRspReady(sel, 1'b0);
    chk("rsp_valid_consumed", validOf(sel), 1'b0);
    chk("req_ready_after", readyOf(sel), 1'b1);
  endtask

  initial begin
    logic [31:0] r, a, d;
    logic e;
    logic [2:0] f;
    int sz, acc0;
    rst = 1'b1; rv0 = 1'b0; rv1 = 1'b0; rsr0 = 1'b0; rsr1 = 1'b0;
    reqWe = 1'b0; reqAddr = 32'd0; reqWdata = 32'd0; reqF3 = 3'd0;
    #1;
    chk("reset_req_ready", rr0, 1'b1);
    chk("reset_rsp_valid", vl0, 1'b0);
    chk("reset_rdata", rd0, 32'd0);
    chk("reset_err", er0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill every word so the model knows all contents.
    for (int i = 0; i < 256; i++) access(0, 1'b1, 32'(i * 4), $urandom, 3'd2, 0, 1'b0, r, e);

    access(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 0, 1'b0, r, e);
    access(0, 1'b0, 32'h10, 32'd0, 3'd2, 0, 1'b0, r, e);
    chk("lw_deadbeef", r, 32'hDEADBEEF);

    access(0, 1'b1, 32'h10, 32'h11223344, 3'd2, 0, 1'b0, r, e);
    access(0, 1'b1, 32'h13, 32'h00000080, 3'd0, 0, 1'b0, r, e);
    chk("sb_rdata_zero", r, 32'd0);
    access(0, 1'b0, 32'h13, 32'd0, 3'd0, 0, 1'b0, r, e);
    chk("lb_sext", r, 32'hFFFFFF80);
    access(0, 1'b0, 32'h13, 32'd0, 3'd4, 0, 1'b0, r, e);
    chk("lbu_zext", r, 32'h00000080);
    access(0, 1'b0, 32'h10, 32'd0, 3'd2, 0, 1'b0, r, e);
    chk("lw_merged", r, 32'h80223344);

    access(0, 1'b0, 32'h11, 32'd0, 3'd1, 0, 1'b0, r, e);
    chk("lh_misaligned_err", e, 1'b1);
    chk("lh_misaligned_rdata", r, 32'd0);
    access(0, 1'b1, 32'h402, 32'hFFFFFFFF, 3'd2, 0, 1'b0, r, e);
    chk("sw_misaligned_err", e, 1'b1);
    access(0, 1'b0, 32'h400, 32'd0, 3'd2, 0, 1'b0, r, e);
    chk("lw_range_err", e, 1'b1);

    // Held response with a spurious store request pending the whole time.
    access(0, 1'b0, 32'h10, 32'd0, 3'd2, 5, 1'b1, r, e);
    access(0, 1'b0, 32'h30, 32'd0, 3'd2, 0, 1'b0, r, e);

    // Reset during WAIT aborts the store.
    @(negedge clk);
    chk("req_ready_pre_abort", rr0, 1'b1);
    reqWe = 1'b1; reqAddr = 32'h20; reqWdata = 32'h12345678; reqF3 = 3'd2; rv0 = 1'b1;
    @(posedge clk);
    #1 rv0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", vl0, 1'b0);
    chk("abort_req_ready", rr0, 1'b1);
    chk("abort_rdata", rd0, 32'd0);
    chk("abort_err", er0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    access(0, 1'b0, 32'h20, 32'd0, 3'd2, 0, 1'b0, r, e);

    // LATENCY=1 instance: response after one cycle, next accept 3 edges later.
    access(1, 1'b1, 32'h40, 32'hA5A55A5A, 3'd2, 0, 1'b0, r, e);
    access(1, 1'b0, 32'h40, 32'd0, 3'd2, 0, 1'b0, r, e);
    chk("lat1_lw", r, 32'hA5A55A5A);
    acc0 = lastAccept;
    access(1, 1'b0, 32'h42, 32'd0, 3'd5, 0, 1'b0, r, e);
    chk("lat1_next_accept", 32'(lastAccept - acc0), 32'd3);

    // Random traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      f = 3'($urandom_range(0, 7));
      a = (($urandom_range(0, 15) == 0) ? 32'($urandom_range(1024, 1400))
                                         : 32'($urandom_range(0, 1023)));
      sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      d = $urandom;
      access(0, 1'($urandom_range(0, 1)), a, d, f, $urandom_range(0, 2), 1'b0, r, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
